// File: rtl/alu_logic_arbiter_if.sv
// Bundle of request/response signals between two requesters and the
// shared logic ALU arbiter. Index i of each vector belongs to requester i.
interface alu_logic_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_cntrl;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_illegal;
    logic             busy;
    logic             grant_id;

    modport master (
        output req_valid, req_a, req_b, req_cntrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_illegal, busy, grant_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cntrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_illegal, busy, grant_id
    );
endinterface

// File: rtl/alu_logic_arbiter.sv
// Two-requester arbiter in front of a single combinational logic ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (register
// result) -> RESP (hold response until owner consumes it).
// Define ALU_LOGIC_ARB_RR_EN for round-robin contention; default is fixed
// priority with requester 0 winning.

module alu_logic (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  cntrl,
    output logic [31:0] result
);
    // AND/OR/XOR select; any other code yields zero
    always_comb begin
        result = '0;
        case (cntrl)
            4'b0100: result = a & b;
            4'b0101: result = a | b;
            4'b0110: result = a ^ b;
            default: result = '0;
        endcase
    end
endmodule

module alu_logic_arbiter (
    input  logic                      clk,
    input  logic                      rst,
    alu_logic_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        winner;
    logic        accept;
    logic [1:0]  ready;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  cntrl_q;
    logic        grant_q;
    logic [31:0] result_q;
    logic        illegal_q;
    logic [31:0] alu_result;
    logic        cntrl_illegal;

`ifdef ALU_LOGIC_ARB_RR_EN
    logic        rr_ptr;

    // Contention goes to the favoured requester; a lone requester always wins
    always_comb begin
        winner = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];
    end

    // Favour the requester that was not granted last
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~winner;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid
    always_comb begin
        winner = ~bus.req_valid[0];
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and accept handshake; reset suppresses any acceptance
    always_comb begin
        state_next = state;
        ready      = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    accept        = 1'b1;
                    ready[winner] = 1'b1;
                    state_next    = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            state_next = IDLE;
            ready      = '0;
            accept     = 1'b0;
        end
    end

    // Latch operands on acceptance; capture the ALU output in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            cntrl_q   <= '0;
            grant_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.req_a[winner];
                b_q     <= bus.req_b[winner];
                cntrl_q <= bus.req_cntrl[winner];
                grant_q <= winner;
            end
            if (state == EXEC) begin
                result_q  <= alu_result;
                illegal_q <= cntrl_illegal;
            end
        end
    end

    alu_logic u_alu (
        .a      (a_q),
        .b      (b_q),
        .cntrl  (cntrl_q),
        .result (alu_result)
    );

    // Flag any latched code outside the three legal operations
    always_comb begin
        cntrl_illegal = !((cntrl_q == 4'b0100) || (cntrl_q == 4'b0101) ||
                          (cntrl_q == 4'b0110));
    end

    // Response steering to the current owner
    always_comb begin
        bus.req_ready   = ready;
        bus.rsp_valid   = '0;
        if (state == RESP) begin
            bus.rsp_valid[grant_q] = 1'b1;
        end
        bus.rsp_result  = result_q;
        bus.rsp_illegal = illegal_q;
        bus.busy        = (state != IDLE);
        bus.grant_id    = grant_q;
    end
endmodule

// File: doc/alu_logic_arbiter.md
ALU_LOGIC_ARBITER -- requirements
Module: alu_logic_arbiter

Interface
REQ-001 SHALL have no parameters; the block serves exactly two requesters (index 0, 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester operation request.
REQ-005 req_ready  output  2  per-requester accept; request accepted on cycle where req_valid[i] & req_ready[i].
REQ-006 req_a  input  2x32  per-requester operand a.
REQ-007 req_b  input  2x32  per-requester operand b.
REQ-008 req_cntrl  input  2x4  per-requester op code: 4'b0100 AND, 4'b0101 OR, 4'b0110 XOR.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result consume; response completes on rsp_valid[i] & rsp_ready[i].
REQ-011 rsp_result  output  32  result, shared bus, meaningful only while some rsp_valid bit is high.
REQ-012 rsp_illegal  output  1  high with rsp_valid when latched cntrl was not one of the three legal codes.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 grant_id  output  1  index of requester currently owning the unit; holds last owner when IDLE.

Function
REQ-015 SHALL instantiate one alu_logic and feed it only from internally latched operands and cntrl.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; no other states reachable.
REQ-017 IDLE: if no req_valid, stay; else select winner per REQ-021/REQ-032, assert req_ready[winner] combinationally that cycle only, latch a, b, cntrl, set grant_id, go EXEC.
REQ-018 req_ready SHALL be 0 for the loser and 0 in EXEC and RESP.
REQ-019 EXEC: register alu_logic output into rsp_result, set rsp_illegal if cntrl illegal (result 0 per alu_logic default), go RESP.
REQ-020 RESP: rsp_valid[grant_id]=1, other bit 0; rsp_result/rsp_illegal stable; on rsp_ready[grant_id] go IDLE; rsp_ready of non-owner ignored.
REQ-021 Arbitration with single valid requester SHALL grant that requester regardless of history.
REQ-022 Latency: accept at cycle N -> rsp_valid at cycle N+2; with rsp_ready held high, next accept earliest at N+3.
REQ-023 Throughput: at most one operation in flight; new requests wait (req_valid held, req_ready low) until IDLE.
REQ-024 Request dropping req_valid while not accepted SHALL simply not be served; no state change.
REQ-025 Operand changes on req_a/req_b/req_cntrl after acceptance SHALL NOT affect the in-flight result.
REQ-026 rsp_valid withheld indefinitely (rsp_ready low) SHALL hold RESP with all outputs unchanged.

Reset
REQ-027 rst high at any clock edge, in any state, SHALL force next state IDLE, abandoning any in-flight operation without response.
REQ-028 Reset values: req_ready=0 during rst cycle, rsp_valid=0, rsp_result=0, rsp_illegal=0, busy=0, grant_id=0, round-robin pointer favouring requester 0.
REQ-029 rst SHALL take priority over every simultaneous request or response handshake.

Configuration
REQ-030 Macro ALU_LOGIC_ARB_RR_EN selects the contention policy; no other behaviour depends on it.
REQ-031 Without ALU_LOGIC_ARB_RR_EN: fixed priority, requester 0 always wins when both valid.
REQ-032 With ALU_LOGIC_ARB_RR_EN: when both valid, grant the requester not served by the most recent completed grant; pointer updated on acceptance; after reset requester 0 wins first contention.

Verification
REQ-033 Single op: req_valid=01, a=0xF0F0_F0F0, b=0xFF00_FF00, cntrl=0100 -> req_ready=01 same cycle, rsp_valid=01 two cycles later, rsp_result=0xF000_F000, rsp_illegal=0.
REQ-034 Contention: both valid continuously, cntrl0=0101, cntrl1=0110, rsp_ready=11 -> with RR_EN grants alternate 0,1,0,1; without, four consecutive grants to 0.
REQ-035 Illegal op: requester 1 cntrl=1111, a=b=0xFFFF_FFFF -> rsp_valid=10, rsp_result=0, rsp_illegal=1.
REQ-036 Backpressure: complete XOR 0x1234_5678^0xFFFF_0000, hold rsp_ready=0 for 5 cycles while requester 0 valid -> rsp_result stable at 0xEDCB_5678, req_ready=00 throughout, accept occurs cycle after rsp_ready=1.
REQ-037 Reset mid-op: assert rst in EXEC -> next cycle busy=0, rsp_valid=00, rsp_result=0, no response ever issued for dropped op.
REQ-038 Operand mutation: change req_a the cycle after acceptance -> result reflects originally latched operands.
